// File: rtl/pong_engine_if.sv
// pong_engine_if: control inputs and display/score outputs of the Pong game core.
interface pong_engine_if #(
  parameter int POS_W   = 11,
  parameter int SCORE_W = 4
);
  logic               tick, start, mode_l, mode_r, up_l, down_l, up_r, down_r;
  logic [POS_W-1:0]   ball_x, ball_y, padl_y, padr_y, speed;
  logic [SCORE_W-1:0] score_l, score_r;
  logic [1:0]         state;
  logic               point, game_over, winner;
  modport master (
    output tick, start, mode_l, mode_r, up_l, down_l, up_r, down_r,
    input  ball_x, ball_y, padl_y, padr_y, speed, score_l, score_r, state, point, game_over, winner
  );
  modport slave (
    input  tick, start, mode_l, mode_r, up_l, down_l, up_r, down_r,
    output ball_x, ball_y, padl_y, padr_y, speed, score_l, score_r, state, point, game_over, winner
  );
endinterface

// File: rtl/pong_engine.sv
// pong_engine: Pong game FSM, ball physics, paddles, scoring and win detection.
// Define PONG_SPEEDUP_EN to raise the ball speed every SPEEDUP paddle hits.
module pong_engine #(
  parameter int H_RES      = 1280,
  parameter int V_RES      = 800,
  parameter int POS_W      = 11,
  parameter int BALL_SIZE  = 20,
  parameter int BALL_SPEED = 10,
  parameter int SPEED_MAX  = 20,
  parameter int SPEEDUP    = 5,
  parameter int PAD_HEIGHT = 100,
  parameter int PAD_WIDTH  = 10,
  parameter int PAD_OFFS   = 35,
  parameter int PAD_SPY    = 15,
  parameter int WIN        = 4,
  parameter int SCORE_W    = 4
) (
  input logic          clk,
  input logic          rst,
  pong_engine_if.slave bus
);
  localparam int W = POS_W + 1;
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  // All geometry is kept one bit wider than the buses so no sum or difference wraps
  localparam logic [W-1:0] BXC  = W'((H_RES - BALL_SIZE) / 2);
  localparam logic [W-1:0] BYC  = W'((V_RES - BALL_SIZE) / 2);
  localparam logic [W-1:0] PADC = W'((V_RES - PAD_HEIGHT) / 2);
  localparam logic [W-1:0] PMAX = W'(V_RES - PAD_HEIGHT);
  localparam logic [W-1:0] XL   = W'(PAD_OFFS + PAD_WIDTH);
  localparam logic [W-1:0] XR   = W'(H_RES - PAD_OFFS - BALL_SIZE);
  localparam logic [W-1:0] XSR  = W'(H_RES - PAD_OFFS - PAD_WIDTH - BALL_SIZE);
  localparam logic [W-1:0] BS   = W'(BALL_SIZE);
  localparam logic [W-1:0] HR   = W'(H_RES);
  localparam logic [W-1:0] VR   = W'(V_RES);
  localparam logic [W-1:0] PH   = W'(PAD_HEIGHT);
  localparam logic [W-1:0] PH2  = W'(PAD_HEIGHT / 2);
  localparam logic [W-1:0] SPY  = W'(PAD_SPY);
  localparam logic [W-1:0] SPD0 = W'(BALL_SPEED);
  localparam logic [SCORE_W-1:0] WINS = SCORE_W'(WIN);
  state_t             r_state;
  logic [POS_W-1:0]   r_bx, r_by, r_pl, r_pr, r_speed;
  logic [SCORE_W-1:0] r_sl, r_sr;
  logic               r_dx, r_dy, r_side, r_point, r_over, r_win;
`ifdef PONG_SPEEDUP_EN
  localparam int HW = $clog2(SPEEDUP + 1);
  localparam logic [HW-1:0]    HLAST = HW'(SPEEDUP - 1);
  localparam logic [POS_W-1:0] SMAX  = POS_W'(SPEED_MAX);
  logic [HW-1:0] r_hits;
`endif
  logic [W-1:0]       w_bx, w_by, w_s, w_pl, w_pr, w_nx, w_ny;
  logic               w_hit_r, w_hit_l, w_hit, w_miss, w_top, w_bot, w_ndy, w_won;
  logic [SCORE_W-1:0] w_sl, w_sr;
  function automatic logic [POS_W-1:0] pad_next(input logic [W-1:0] p, by, input logic ai, up, dn);
    logic         go_dn, go_up;
    logic [W-1:0] nx;
    go_dn = ai ? (p + PH2 < by) : (dn && !up);
    go_up = ai ? (p + PH2 > by + BS) : (up && !dn);
    nx = go_dn ? ((p + SPY > PMAX) ? PMAX : p + SPY) : (go_up ? ((p < SPY) ? '0 : p - SPY) : p);
    return nx[POS_W-1:0];
  endfunction
  assign w_bx    = {1'b0, r_bx};
  assign w_by    = {1'b0, r_by};
  assign w_s     = {1'b0, r_speed};
  assign w_pl    = {1'b0, r_pl};
  assign w_pr    = {1'b0, r_pr};
  assign w_hit_r = (w_bx + BS <= XR) && (w_bx + BS + w_s >= XR) && (w_pr <= w_by + BS) && (w_pr + PH >= w_by);
  assign w_hit_l = (w_bx >= XL) && (w_bx <= XL + w_s) && (w_pl <= w_by + BS) && (w_pl + PH >= w_by);
  assign w_hit   = r_dx ? w_hit_l : w_hit_r;
  assign w_miss  = !w_hit && (r_dx ? (w_bx < w_s) : (w_bx + BS + w_s >= HR));
  assign w_nx    = w_hit ? (r_dx ? XL : XR - BS) : (r_dx ? w_bx - w_s : w_bx + w_s);
  assign w_top   = w_by < w_s;
  assign w_bot   = w_by + BS + w_s >= VR;
  assign w_ny    = r_dy ? (w_top ? '0 : w_by - w_s) : (w_bot ? VR - BS : w_by + w_s);
  assign w_ndy   = r_dy ? !w_top : w_bot;
  assign w_sl    = r_sl + 1'b1;
  assign w_sr    = r_sr + 1'b1;
  assign w_won   = r_dx ? (w_sr == WINS) : (w_sl == WINS);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_bx    <= BXC[POS_W-1:0];
      r_by    <= BYC[POS_W-1:0];
      r_pl    <= PADC[POS_W-1:0];
      r_pr    <= PADC[POS_W-1:0];
      r_speed <= SPD0[POS_W-1:0];
      r_sl    <= '0;
      r_sr    <= '0;
      r_dx    <= 1'b0;
      r_dy    <= 1'b0;
      r_side  <= 1'b0;
      r_point <= 1'b0;
      r_over  <= 1'b0;
      r_win   <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      r_hits  <= '0;
`endif
    end else begin
      r_point <= 1'b0;
      case (r_state)
        IDLE, OVER: if (bus.start) begin
          r_state <= SERVE;
          r_sl    <= '0;
          r_sr    <= '0;
          r_over  <= 1'b0;
        end
        SERVE: if (bus.tick) begin
          r_state <= PLAY;
          r_pl    <= PADC[POS_W-1:0];
          r_pr    <= PADC[POS_W-1:0];
          r_by    <= BYC[POS_W-1:0];
          r_bx    <= r_side ? XSR[POS_W-1:0] : XL[POS_W-1:0];
          r_dx    <= r_side;
          r_dy    <= 1'b0;
          r_speed <= SPD0[POS_W-1:0];
`ifdef PONG_SPEEDUP_EN
          r_hits  <= '0;
`endif
        end
        PLAY: if (bus.tick) begin
          r_pl <= pad_next(w_pl, w_by, bus.mode_l, bus.up_l, bus.down_l);
          r_pr <= pad_next(w_pr, w_by, bus.mode_r, bus.up_r, bus.down_r);
          // A miss freezes the ball; the side that missed serves next
          if (w_miss) begin
            r_point <= 1'b1;
            r_side  <= !r_dx;
            r_state <= w_won ? OVER : SERVE;
            r_over  <= w_won;
            if (w_won) r_win <= r_dx;
            if (r_dx) r_sr <= w_sr;
            else r_sl <= w_sl;
          end else begin
            r_bx <= w_nx[POS_W-1:0];
            r_by <= w_ny[POS_W-1:0];
            r_dx <= r_dx ^ w_hit;
            r_dy <= w_ndy;
`ifdef PONG_SPEEDUP_EN
            if (w_hit) begin
              r_hits <= (r_hits == HLAST) ? '0 : r_hits + 1'b1;
              if (r_hits == HLAST && r_speed < SMAX) r_speed <= r_speed + 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end
  assign bus.ball_x    = r_bx;
  assign bus.ball_y    = r_by;
  assign bus.padl_y    = r_pl;
  assign bus.padr_y    = r_pr;
  assign bus.speed     = r_speed;
  assign bus.score_l   = r_sl;
  assign bus.score_r   = r_sr;
  assign bus.state     = r_state;
  assign bus.point     = r_point;
  assign bus.game_over = r_over;
  assign bus.winner    = r_win;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed checks of reset, serve, paddle clamp, misses, win and speed-up.
module tb_pong_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int n, rev, dir, d;
  logic [10:0] px, spd4;
  pong_engine_if bus ();
  pong_engine dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick1();
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
  endtask
  task automatic start1();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.tick = 0; bus.start = 0; bus.mode_l = 0; bus.mode_r = 0;
    bus.up_l = 0; bus.down_l = 0; bus.up_r = 0; bus.down_r = 0;
    repeat (2) @(negedge clk);
    chk("rst_bx", bus.ball_x, 630);
    chk("rst_by", bus.ball_y, 390);
    chk("rst_pl", bus.padl_y, 350);
    chk("rst_pr", bus.padr_y, 350);
    chk("rst_sl", bus.score_l, 0);
    chk("rst_sr", bus.score_r, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_speed", bus.speed, 10);
    chk("rst_flags", {bus.point, bus.game_over, bus.winner}, 0);
    rst = 1'b0;
    tick1();
    chk("idle_tick_state", bus.state, 0);
    chk("idle_tick_bx", bus.ball_x, 630);
    @(negedge clk) begin bus.start = 1'b1; bus.tick = 1'b1; end
    @(negedge clk) begin bus.start = 1'b0; bus.tick = 1'b0; end
    chk("start_tick_state", bus.state, 1);
    chk("start_tick_bx", bus.ball_x, 630);
    tick1();
    chk("serve_bx", bus.ball_x, 45);
    chk("serve_by", bus.ball_y, 390);
    chk("serve_state", bus.state, 2);
    tick1();
    chk("move1_bx", bus.ball_x, 55);
    chk("move1_by", bus.ball_y, 400);
    start1();
    chk("play_start_ignored", bus.state, 2);
    bus.down_l = 1'b1;
    bus.down_r = 1'b1;
    repeat (23) tick1();
    chk("pad_l_695", bus.padl_y, 695);
    tick1();
    chk("pad_l_clamp", bus.padl_y, 700);
    chk("pad_r_clamp", bus.padr_y, 700);
    bus.up_l = 1'b1;
    tick1();
    chk("pad_l_both_hold", bus.padl_y, 700);
    chk("k26_bx", bus.ball_x, 305);
    chk("k26_by", bus.ball_y, 650);
    bus.up_l = 1'b0;
    bus.down_l = 1'b0;
    repeat (95) tick1();
    chk("k121_bx", bus.ball_x, 1255);
    chk("k121_by", bus.ball_y, 30);
    chk("k121_sl", bus.score_l, 0);
    tick1();
    chk("miss_point", bus.point, 1);
    chk("miss_sl", bus.score_l, 1);
    chk("miss_sr", bus.score_r, 0);
    chk("miss_state", bus.state, 1);
    chk("miss_frozen_bx", bus.ball_x, 1255);
    @(negedge clk);
    chk("point_one_cycle", bus.point, 0);
    tick1();
    chk("serve_r_bx", bus.ball_x, 1215);
    chk("serve_r_by", bus.ball_y, 390);
    chk("serve_r_pr", bus.padr_y, 350);
    tick1();
    chk("serve_r_left_bx", bus.ball_x, 1205);
    chk("serve_r_left_by", bus.ball_y, 400);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("async_rst_bx", bus.ball_x, 630);
    chk("async_rst_state", bus.state, 0);
    chk("async_rst_sl", bus.score_l, 0);
    @(negedge clk) rst = 1'b0;
    bus.mode_l = 1'b1;
    start1();
    for (int i = 1; i <= 4; i++) begin
      n = 0;
      while (bus.point !== 1'b1 && n < 400) begin
        tick1();
        n++;
      end
      chk("win_point_seen", bus.point, 1);
      chk("win_sl", bus.score_l, i);
      chk("win_sr", bus.score_r, 0);
      chk("win_state", bus.state, (i < 4) ? 1 : 3);
      @(negedge clk);
    end
    chk("over_flag", bus.game_over, 1);
    chk("over_winner", bus.winner, 0);
    chk("over_bx", bus.ball_x, 1255);
    chk("over_by", bus.ball_y, 360);
    repeat (3) tick1();
    chk("over_hold_state", bus.state, 3);
    chk("over_hold_bx", bus.ball_x, 1255);
    chk("over_hold_sl", bus.score_l, 4);
    start1();
    chk("restart_state", bus.state, 1);
    chk("restart_sl", bus.score_l, 0);
    chk("restart_over", bus.game_over, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    bus.mode_l = 1'b1;
    bus.mode_r = 1'b1;
    bus.down_r = 1'b0;
    start1();
    tick1();
    n = 0; rev = 0; dir = 0; px = bus.ball_x; spd4 = '0;
    while (rev < 5 && n < 3000) begin
      tick1();
      n++;
      d = (bus.ball_x > px) ? 1 : (bus.ball_x < px) ? -1 : 0;
      if (d != 0 && dir != 0 && d != dir) begin
        rev++;
        if (rev == 4) spd4 = bus.speed;
      end
      if (d != 0) dir = d;
      px = bus.ball_x;
    end
    chk("spd_hits", rev, 5);
    chk("spd_after4", spd4, 10);
`ifdef PONG_SPEEDUP_EN
    chk("spd_after5", bus.speed, 11);
`else
    chk("spd_after5", bus.speed, 10);
`endif
    chk("spd_sl", bus.score_l, 0);
    chk("spd_sr", bus.score_r, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
